stream_mux_rr: RTL and testbench

Parametrised N-channel to one stream multiplexer with a valid/ready handshake on every port, round-robin or fixed-select arbitration, and a one-entry registered output stage. It generalises the team's single-bit combinational 2:1/4:1 muxes to multi-bit, multi-channel datapaths with flow control. It sits between several producer units and one shared consumer, such as a shared bus port or writeback path.

---
 rtl/stream_mux_rr.sv | 108 ++++++++++
 tb/tb_stream_mux_rr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux: round-robin or fixed-select grant into one registered output slot.
// Latency 1 cycle; in_ready is combinational and only the granted channel is ever ready, gated by output-slot space.
module stream_mux_rr #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    localparam logic [SELW:0]   NCH_W = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  chan_q, chan_d;

    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  gidx;
    logic             gvld;
    logic [SELW:0]    cand;
    logic             can_accept;
    logic             xfer;

    assign can_accept = !vld_q || out_ready;
    assign xfer       = gvld && can_accept;

    // Arbitration: cand carries one spare bit so ptr+k can wrap without overflow.
    always_comb begin
        gvld = 1'b0;
        gidx = '0;
        cand = '0;
        if (mode) begin
            if (({1'b0, sel} < NCH_W) && in_valid[sel]) begin
                gvld = 1'b1;
                gidx = sel;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cand = {1'b0, ptr_q} + (SELW+1)'(k);
                if (cand >= NCH_W) begin
                    cand = cand - NCH_W;
                end
                if (!gvld && in_valid[cand[SELW-1:0]]) begin
                    gvld = 1'b1;
                    gidx = cand[SELW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (gvld) begin
            grant[gidx] = 1'b1;
        end
    end

    assign in_ready = grant & {NCH{can_accept}};

    // A load always wins over a drain so back-to-back beats never bubble.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        chan_d = chan_q;
        ptr_d  = ptr_q;
        if (xfer) begin
            vld_d  = 1'b1;
            data_d = in_data[gidx*WIDTH +: WIDTH];
            chan_d = gidx;
            if (!mode) begin
                ptr_d = (gidx == LAST) ? '0 : gidx + 1'b1;
            end
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            chan_q <= '0;
            ptr_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            chan_q <= chan_d;
            ptr_q  <= ptr_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr at NCH=4, WIDTH=8; outputs sampled 1 time unit after the rising edge.
module tb_stream_mux_rr;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 clk_en;
    logic                 reset;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic [SELW-1:0]      out_chan;
    logic                 out_ready;

    int checks   = 0;
    int failures = 0;

    stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk_en    = 1'b0;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;

        // Reset with no clock running
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_chan",  32'(out_chan),  32'd0);

        clk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ready", 32'(in_ready),  32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
        end

        // Round-robin fairness, all channels valid
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("rr_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_chan",  32'(out_chan),  32'(k % 4));
            check("rr_data",  32'(out_data),  32'(8'hA0 + (k % 4)));
        end
        in_valid = '0;
        #1;
        check("rr_idle_ready", 32'(in_ready), 32'd0);
        tick();
        check("rr_drain", 32'(out_valid), 32'd0);

        // Backpressure on channel 2
        out_ready = 1'b0;
        in_data   = {8'h00, 8'h55, 8'h00, 8'h00};
        in_valid  = 4'b0100;
        #1;
        check("bp_ready_load", 32'(in_ready), 32'b0100);
        tick();
        in_valid = 4'hF;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_stall", 32'(in_ready),  32'd0);
            check("bp_valid",       32'(out_valid), 32'd1);
            check("bp_data",        32'(out_data),  32'h55);
            check("bp_chan",        32'(out_chan),  32'd2);
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        #1;
        check("bp_beat_offered", 32'(out_valid), 32'd1);
        tick();
        check("bp_after_beat", 32'(out_valid), 32'd0);
        tick();
        check("bp_stays_empty", 32'(out_valid), 32'd0);

        // Sparse round-robin: move ptr to 2 via a channel-1 transfer, then channels 1 and 3
        in_data  = {8'h00, 8'h00, 8'h11, 8'h00};
        in_valid = 4'b0010;
        #1;
        check("sp_setup_ready", 32'(in_ready), 32'b0010);
        tick();
        check("sp_setup_chan", 32'(out_chan), 32'd1);
        in_data  = {8'h23, 8'h00, 8'h21, 8'h00};
        in_valid = 4'b1010;
        #1;
        check("sp_ready0", 32'(in_ready), 32'b1000);
        tick();
        check("sp_chan0", 32'(out_chan), 32'd3);
        check("sp_data0", 32'(out_data), 32'h23);
        check("sp_ready1", 32'(in_ready), 32'b0010);
        tick();
        check("sp_chan1", 32'(out_chan), 32'd1);
        check("sp_data1", 32'(out_data), 32'h21);
        check("sp_ready2", 32'(in_ready), 32'b1000);
        tick();
        check("sp_chan2", 32'(out_chan), 32'd3);
        in_valid = '0;
        tick();
        check("sp_drain", 32'(out_valid), 32'd0);

        // Fixed select on channel 2
        mode     = 1'b1;
        sel      = 2'd2;
        in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid = 4'hF;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("fx_ready", 32'(in_ready), 32'b0100);
            tick();
            check("fx_chan", 32'(out_chan), 32'd2);
            check("fx_data", 32'(out_data), 32'hA2);
        end
        in_valid = 4'b1011;
        #1;
        check("fx_ready_none", 32'(in_ready), 32'd0);
        tick();
        check("fx_no_xfer", 32'(out_valid), 32'd0);
        sel = 2'd1;
        #1;
        check("fx_sel_change", 32'(in_ready), 32'b0010);

        // Reset mid-stream with 0x77 held under backpressure
        mode      = 1'b0;
        out_ready = 1'b0;
        in_data   = {8'h00, 8'h77, 8'h00, 8'h00};
        in_valid  = 4'b0100;
        #1;
        check("mr_ready_load", 32'(in_ready), 32'b0100);
        tick();
        in_valid = '0;
        tick();
        check("mr_held_valid", 32'(out_valid), 32'd1);
        check("mr_held_data",  32'(out_data),  32'h77);
        #2;
        reset = 1'b1;
        #1;
        check("mr_async_valid", 32'(out_valid), 32'd0);
        check("mr_async_data",  32'(out_data),  32'd0);
        tick();
        reset     = 1'b0;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        check("mr_ptr_ready", 32'(in_ready), 32'b0001);
        tick();
        check("mr_first_chan", 32'(out_chan), 32'd0);
        check("mr_first_data", 32'(out_data), 32'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
